fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decode-stage hazard logic.
- Owns the PC register, next-PC selection (sequential, branch, jump), the instruction-memory request handshake and the IF/ID pipeline register.
- Consumes pc_write / ifid_write / if_flush from the hazard unit. Produces the IF/ID instruction and PC+4 that decode and the hazard unit read.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted as a bubble (MIPS sll $0,$0,0).

Ports:
- clk  input  1  stage clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_write  input  1  1 = PC may update this cycle.
- ifid_write  input  1  1 = IF/ID register may update this cycle.
- if_flush  input  1  1 = replace IF/ID contents with a bubble.
- jump  input  1  jump redirect request from decode.
- jump_target  input  32  jump destination.
- branch_taken  input  1  taken branch (beq/bne resolved in decode).
- branch_target  input  32  branch destination.
- imem_req  output  1  instruction fetch request.
- imem_addr  output  32  fetch address (= current PC).
- imem_ready  input  1  imem_rdata valid for imem_addr this cycle.
- imem_rdata  input  32  fetched instruction word.
- ifid_instr  output  32  IF/ID instruction.
- ifid_pc4  output  32  IF/ID PC+4.
- ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- fetch_stall  output  1  1 when fetch did not complete this cycle.
- perf_fetch_cnt  output  32  fetched-instruction counter (see Optional Feature).
- perf_stall_cnt  output  32  memory-stall cycle counter (see Optional Feature).

Behaviour:
- Reset (rst=1 at an edge), from any state and including mid-wait:
  - pc=PC_RESET, state=BOOT.
  - ifid_instr=NOP_INSTR, ifid_pc4=0, ifid_valid=0, counters=0.
- Outputs during reset/BOOT: imem_req=0, fetch_stall=1.
- FSM states BOOT, RUN, WAIT:
  - BOOT -> RUN unconditionally after one cycle; no fetch is issued in BOOT.
  - RUN -> WAIT when imem_ready=0; otherwise stays RUN.
  - WAIT -> RUN when imem_ready=1.
- imem_req=1 in RUN and WAIT. imem_addr=pc (combinational from the register). imem_addr is always word-aligned.
- fetch_ok = imem_req & imem_ready. fetch_stall = ~fetch_ok.
- PC update, when pc_write=1, in priority order:
  1. jump -> {jump_target[31:2],2'b00}.
  2. branch_taken -> {branch_target[31:2],2'b00}.
  3. fetch_ok -> pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
  4. else hold.
- pc_write=0 holds the PC unconditionally, redirects included.
- A redirect in WAIT abandons the outstanding fetch. The new PC is presented next cycle and the FSM stays in WAIT until imem_ready.
- IF/ID update when ifid_write=1:
  - if_flush=1 or jump=1 or branch_taken=1 -> bubble: instr=NOP_INSTR, valid=0, pc4 unchanged.
  - else fetch_ok -> instr=imem_rdata, pc4=pc+4, valid=1.
  - else bubble (instr=NOP_INSTR, valid=0).
- ifid_write=0 holds IF/ID entirely. if_flush and redirects are ignored for IF/ID that cycle, because a stalled branch decision is not final.
- Latency: one cycle from imem_ready=1 to the instruction appearing in IF/ID. Steady-state throughput is one instruction per cycle with imem_ready=1.
- Load-use stall (pc_write=0, ifid_write=0): the fetch at the same PC repeats; the instruction is not lost because the PC did not advance.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - perf_fetch_cnt increments on each cycle with fetch_ok & pc_write & ifid_write & ~if_flush & ~jump & ~branch_taken.
  - perf_stall_cnt increments on each cycle the FSM is in RUN or WAIT with imem_ready=0.
  - Both counters saturate at 32'hFFFF_FFFF and clear on rst.
- Undefined: both ports remain and are tied to 0; no counter flops are built.

Test Plan:
- Reset then imem_ready=1 constant, PC_RESET=0 -> BOOT 1 cycle; imem_addr sequence 0,4,8; ifid_pc4 4,8,12 one cycle after each fetch; ifid_valid=1 from 2nd cycle after reset release.
- imem_ready low 3 cycles at addr 0x10 -> imem_addr holds 0x10; ifid_valid=0 for 3 cycles; fetch_stall=1; perf_stall_cnt=3 with FETCH_PERF_EN.
- jump=1, jump_target=0x0000_0403, pc_write=1, ifid_write=1 -> next imem_addr=0x400; IF/ID=NOP_INSTR, valid=0; branch_taken same cycle loses to jump.
- pc_write=0, ifid_write=0, if_flush=1 for 1 cycle at pc=0x20 with IF/ID holding 0x8C01_0004 -> PC stays 0x20; IF/ID unchanged, valid=1.
- pc=0xFFFF_FFFC, fetch_ok -> next pc=0; ifid_pc4=0.
- rst asserted while in WAIT with a pending redirect -> pc=PC_RESET; ifid_valid=0; imem_req=0 next cycle; counters=0.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, next-PC select, imem handshake, IF/ID register
// Optional performance counters are built only when FETCH_PERF_EN is defined.
module fetch_stage #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_write,
    input  logic        ifid_write,
    input  logic        if_flush,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        fetch_stall,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        fetch_ok;
    logic        redirect;
    logic [31:0] pc_plus4;
    logic        unused_lsbs;

    assign fetch_ok    = imem_req & imem_ready;
    assign fetch_stall = ~fetch_ok;
    assign redirect    = jump | branch_taken;
    assign pc_plus4    = pc + 32'd4;
    assign imem_addr   = pc;
    // Targets are forced to word alignment, so their low bits never matter.
    assign unused_lsbs = ^{jump_target[1:0], branch_target[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT;
            imem_req   <= 1'b0;
            pc         <= {PC_RESET[31:2], 2'b00};
            ifid_instr <= NOP_INSTR;
            ifid_pc4   <= 32'd0;
            ifid_valid <= 1'b0;
        end else begin
            // Every state except BOOT leads to RUN or WAIT, both of which request.
            imem_req <= 1'b1;
            case (state)
                BOOT:    state <= RUN;
                RUN:     if (!imem_ready) state <= WAIT;
                WAIT:    if (imem_ready)  state <= RUN;
                default: state <= BOOT;
            endcase

            if (pc_write) begin
                if (jump)
                    pc <= {jump_target[31:2], 2'b00};
                else if (branch_taken)
                    pc <= {branch_target[31:2], 2'b00};
                else if (fetch_ok)
                    pc <= pc_plus4;
            end

            // A held IF/ID ignores flush/redirect: the stalled decision is not final.
            if (ifid_write) begin
                if (if_flush || redirect) begin
                    ifid_instr <= NOP_INSTR;
                    ifid_valid <= 1'b0;
                end else if (fetch_ok) begin
                    ifid_instr <= imem_rdata;
                    ifid_pc4   <= pc_plus4;
                    ifid_valid <= 1'b1;
                end else begin
                    ifid_instr <= NOP_INSTR;
                    ifid_valid <= 1'b0;
                end
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic fetch_cnt_en;
    logic stall_cnt_en;

    assign fetch_cnt_en = fetch_ok & pc_write & ifid_write & ~if_flush & ~redirect;
    assign stall_cnt_en = imem_req & ~imem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (fetch_cnt_en && perf_fetch_cnt != 32'hFFFF_FFFF)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stall_cnt_en && perf_stall_cnt != 32'hFFFF_FFFF)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`else
    assign perf_fetch_cnt = 32'd0;
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write;
    logic        ifid_write;
    logic        if_flush;
    logic        jump;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        fetch_stall;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .if_flush       (if_flush),
        .jump           (jump),
        .jump_target    (jump_target),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .ifid_instr     (ifid_instr),
        .ifid_pc4       (ifid_pc4),
        .ifid_valid     (ifid_valid),
        .fetch_stall    (fetch_stall),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; pc_write = 1'b1; ifid_write = 1'b1; if_flush = 1'b0;
        jump = 1'b0; jump_target = 32'h0; branch_taken = 1'b0; branch_target = 32'h0;
        imem_ready = 1'b1; imem_rdata = 32'h0;

        tick();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_stall", {31'd0, fetch_stall}, 32'd1);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'd0, ifid_valid}, 32'd0);
        check("rst_instr", ifid_instr, 32'h0);
        check("rst_pc4", ifid_pc4, 32'h0);
        check("rst_fcnt", perf_fetch_cnt, 32'd0);

        rst = 1'b0;
        #1;
        check("boot_req", {31'd0, imem_req}, 32'd0);
        tick();
        check("run_req", {31'd0, imem_req}, 32'd1);
        check("run_addr0", imem_addr, 32'h0);
        check("run_bubble", {31'd0, ifid_valid}, 32'd0);
        imem_rdata = 32'h2000_0000; #1;
        check("run_stall0", {31'd0, fetch_stall}, 32'd0);

        tick();
        check("seq_addr4", imem_addr, 32'h4);
        check("seq_pc4_4", ifid_pc4, 32'h4);
        check("seq_instr0", ifid_instr, 32'h2000_0000);
        check("seq_valid", {31'd0, ifid_valid}, 32'd1);
        imem_rdata = 32'h2000_0004;
        tick();
        check("seq_addr8", imem_addr, 32'h8);
        check("seq_pc4_8", ifid_pc4, 32'h8);
        imem_rdata = 32'h2000_0008;
        tick();
        check("seq_addr12", imem_addr, 32'hC);
        check("seq_pc4_12", ifid_pc4, 32'hC);
        imem_rdata = 32'h2000_000C;
        tick();
        check("seq_addr16", imem_addr, 32'h10);

        // Memory stall of three cycles at 0x10
        imem_ready = 1'b0; #1;
        check("wait_stall_comb", {31'd0, fetch_stall}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_addr", imem_addr, 32'h10);
            check("wait_valid", {31'd0, ifid_valid}, 32'd0);
            check("wait_stall", {31'd0, fetch_stall}, 32'd1);
        end
        check("wait_scnt", perf_stall_cnt, PERF ? 32'd3 : 32'd0);
        imem_ready = 1'b1; imem_rdata = 32'h2000_0010;
        tick();
        check("resume_addr", imem_addr, 32'h14);
        check("resume_instr", ifid_instr, 32'h2000_0010);
        check("resume_pc4", ifid_pc4, 32'h14);
        check("resume_valid", {31'd0, ifid_valid}, 32'd1);
        check("resume_fcnt", perf_fetch_cnt, PERF ? 32'd5 : 32'd0);

        // Jump beats a simultaneous taken branch; low target bits dropped
        jump = 1'b1; jump_target = 32'h0000_0403;
        branch_taken = 1'b1; branch_target = 32'h0000_0800;
        imem_rdata = 32'h2000_0014;
        tick();
        check("jump_addr", imem_addr, 32'h400);
        check("jump_instr", ifid_instr, 32'h0);
        check("jump_valid", {31'd0, ifid_valid}, 32'd0);
        check("jump_pc4", ifid_pc4, 32'h14);

        branch_taken = 1'b0; jump_target = 32'h0000_001C;
        tick();
        check("jump2_addr", imem_addr, 32'h1C);
        jump = 1'b0; imem_rdata = 32'h8C01_0004;
        tick();
        check("lw_addr", imem_addr, 32'h20);
        check("lw_instr", ifid_instr, 32'h8C01_0004);

        // Load-use stall with a flush that must be ignored
        pc_write = 1'b0; ifid_write = 1'b0; if_flush = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        check("hold_addr", imem_addr, 32'h20);
        check("hold_instr", ifid_instr, 32'h8C01_0004);
        check("hold_valid", {31'd0, ifid_valid}, 32'd1);
        check("hold_pc4", ifid_pc4, 32'h20);
        pc_write = 1'b1; ifid_write = 1'b1; if_flush = 1'b0;

        // Branch to the top word, then wrap
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
        tick();
        check("br_addr", imem_addr, 32'hFFFF_FFFC);
        check("br_valid", {31'd0, ifid_valid}, 32'd0);
        branch_taken = 1'b0; imem_rdata = 32'h1111_2222;
        tick();
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_pc4", ifid_pc4, 32'h0);
        check("wrap_instr", ifid_instr, 32'h1111_2222);
        check("wrap_fcnt", perf_fetch_cnt, PERF ? 32'd7 : 32'd0);

        // Plain flush: PC advances, IF/ID becomes a bubble
        if_flush = 1'b1; imem_rdata = 32'h3333_4444;
        tick();
        check("flush_addr", imem_addr, 32'h4);
        check("flush_valid", {31'd0, ifid_valid}, 32'd0);
        check("flush_instr", ifid_instr, 32'h0);
        if_flush = 1'b0;

        // Redirect during WAIT, then reset with a redirect pending
        imem_ready = 1'b0;
        tick();
        check("w2_addr", imem_addr, 32'h4);
        jump = 1'b1; jump_target = 32'h0000_0300;
        tick();
        check("wredir_addr", imem_addr, 32'h300);
        check("wredir_stall", {31'd0, fetch_stall}, 32'd1);
        check("wredir_scnt", perf_stall_cnt, PERF ? 32'd5 : 32'd0);
        jump_target = 32'h0000_0500; rst = 1'b1;
        tick();
        check("rst2_addr", imem_addr, 32'h0);
        check("rst2_req", {31'd0, imem_req}, 32'd0);
        check("rst2_valid", {31'd0, ifid_valid}, 32'd0);
        check("rst2_fcnt", perf_fetch_cnt, 32'd0);
        check("rst2_scnt", perf_stall_cnt, 32'd0);

        rst = 1'b0; jump = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h5555_6666;
        tick();
        check("post_req", {31'd0, imem_req}, 32'd1);
        check("post_addr", imem_addr, 32'h0);
        tick();
        check("post_addr4", imem_addr, 32'h4);
        check("post_instr", ifid_instr, 32'h5555_6666);
        check("post_valid", {31'd0, ifid_valid}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
